// File: rtl/target_gen_pred.sv
// Fetch-stage static target generator and BTFN branch predictor.
// Define TGT_GEN_STATS_EN to add prediction statistics counters.
module target_gen_pred #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      sel,
   input  logic            en,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target,
   output logic            target_taken,
   output logic [XLEN-1:0] target_q,
   output logic            target_taken_q
`ifdef TGT_GEN_STATS_EN
   ,
   output logic [31:0]     pred_jump_cnt,
   output logic [31:0]     pred_br_taken_cnt,
   output logic [31:0]     pred_br_nt_cnt
`endif
);

   localparam logic [1:0] TGT_GEN_JAL  = 2'b00;
   localparam logic [1:0] TGT_GEN_JALR = 2'b01;
   localparam logic [1:0] TGT_GEN_BR   = 2'b10;

   logic [XLEN-1:0] target_d;
   logic            target_taken_d;

   // Only the selected operand reaches the adder, so a don't-care rd1/imm
   // can never leak into the result.
   always_comb begin
      target_d       = '0;
      target_taken_d = 1'b0;
      if (en) begin
         case (sel)
            TGT_GEN_JAL: begin
               target_d       = pc + imm;
               target_taken_d = 1'b1;
            end
            TGT_GEN_JALR: begin
               target_d       = pc + rd1;
               target_taken_d = 1'b1;
            end
            TGT_GEN_BR: begin
               if (imm[XLEN-1]) begin
                  target_d       = pc + imm;
                  target_taken_d = 1'b1;
               end
            end
            default: begin
               target_d       = '0;
               target_taken_d = 1'b0;
            end
         endcase
      end
   end

   assign target       = target_d;
   assign target_taken = target_taken_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q       <= '0;
         target_taken_q <= 1'b0;
      end else begin
         target_q       <= target_d;
         target_taken_q <= target_taken_d;
      end
   end

`ifdef TGT_GEN_STATS_EN
   logic [31:0] pred_jump_cnt_q,     pred_jump_cnt_d;
   logic [31:0] pred_br_taken_cnt_q, pred_br_taken_cnt_d;
   logic [31:0] pred_br_nt_cnt_q,    pred_br_nt_cnt_d;

   always_comb begin
      pred_jump_cnt_d     = pred_jump_cnt_q;
      pred_br_taken_cnt_d = pred_br_taken_cnt_q;
      pred_br_nt_cnt_d    = pred_br_nt_cnt_q;
      if (en) begin
         if (sel == TGT_GEN_JAL || sel == TGT_GEN_JALR)
            pred_jump_cnt_d = pred_jump_cnt_q + 32'd1;
         else if (sel == TGT_GEN_BR) begin
            if (target_taken_d)
               pred_br_taken_cnt_d = pred_br_taken_cnt_q + 32'd1;
            else
               pred_br_nt_cnt_d = pred_br_nt_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_jump_cnt_q     <= '0;
         pred_br_taken_cnt_q <= '0;
         pred_br_nt_cnt_q    <= '0;
      end else begin
         pred_jump_cnt_q     <= pred_jump_cnt_d;
         pred_br_taken_cnt_q <= pred_br_taken_cnt_d;
         pred_br_nt_cnt_q    <= pred_br_nt_cnt_d;
      end
   end

   assign pred_jump_cnt     = pred_jump_cnt_q;
   assign pred_br_taken_cnt = pred_br_taken_cnt_q;
   assign pred_br_nt_cnt    = pred_br_nt_cnt_q;
`endif

endmodule

// File: tb/tb_target_gen_pred.sv
// Directed self-checking bench for target_gen_pred (combinational, registered, reset, stats).
module tb_target_gen_pred;

   localparam logic [1:0] JAL  = 2'b00;
   localparam logic [1:0] JALR = 2'b01;
   localparam logic [1:0] BR   = 2'b10;
   localparam logic [1:0] BAD  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, rd1, imm;
   logic [1:0]  sel;
   logic        en;
   logic [31:0] target, target_q;
   logic        target_taken, target_taken_q;
`ifdef TGT_GEN_STATS_EN
   logic [31:0] pred_jump_cnt, pred_br_taken_cnt, pred_br_nt_cnt;
`endif

   int checks = 0;
   int failures = 0;

   target_gen_pred #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .sel            (sel),
      .en             (en),
      .rd1            (rd1),
      .imm            (imm),
      .target         (target),
      .target_taken   (target_taken),
      .target_q       (target_q),
      .target_taken_q (target_taken_q)
`ifdef TGT_GEN_STATS_EN
      ,
      .pred_jump_cnt     (pred_jump_cnt),
      .pred_br_taken_cnt (pred_br_taken_cnt),
      .pred_br_nt_cnt    (pred_br_nt_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [1:0] s, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] r);
      en = e; sel = s; pc = p; imm = i; rd1 = r;
   endtask

   task automatic comb(input string tag, input logic e, input logic [1:0] s,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] r,
                       input logic [31:0] exp_t, input logic exp_k);
      drive(e, s, p, i, r);
      #1;
      chk({tag, "_tgt"}, target, exp_t);
      chk({tag, "_tkn"}, {31'd0, target_taken}, {31'd0, exp_k});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, JAL, 32'h0, 32'h0, 32'h0);
      #2;
      chk("rst_tq", target_q, 32'h0);
      chk("rst_kq", {31'd0, target_taken_q}, 32'h0);

      // combinational path is independent of reset
      comb("en0_jal",   1'b0, JAL,  32'h1000,     32'd12,       32'h0,        32'h0,        1'b0);
      comb("en0_br",    1'b0, BR,   32'h1000,     32'hFFFFFFFC, 32'h0,        32'h0,        1'b0);
      comb("jal_pos",   1'b1, JAL,  32'h1000,     32'd12,       32'h5555,     32'h100C,     1'b1);
      comb("jal_neg",   1'b1, JAL,  32'h1000,     32'hFFFFFFF0, 32'h0,        32'h0FF0,     1'b1);
      comb("jal_wrap",  1'b1, JAL,  32'hFFFFFFFC, 32'd8,        32'h0,        32'h4,        1'b1);
      comb("jalr_pos",  1'b1, JALR, 32'h2000,     32'hDEADBEEF, 32'd32,       32'h2020,     1'b1);
      comb("jalr_neg",  1'b1, JALR, 32'h2000,     32'h0,        32'hFFFFFFE0, 32'h1FE0,     1'b1);
      comb("jalr_wrap", 1'b1, JALR, 32'hFFFFFFF0, 32'h4,        32'd64,       32'h30,       1'b1);
      comb("jalr_odd",  1'b1, JALR, 32'h2000,     32'h0,        32'd3,        32'h2003,     1'b1);
      comb("br_back",   1'b1, BR,   32'h3000,     32'hFFFFFFFC, 32'h7,        32'h2FFC,     1'b1);
      comb("br_fwd",    1'b1, BR,   32'h3000,     32'd64,       32'h0,        32'h0,        1'b0);
      comb("br_zero",   1'b1, BR,   32'h3000,     32'd0,        32'h0,        32'h0,        1'b0);
      comb("br_minneg", 1'b1, BR,   32'h8,        32'h80000000, 32'h0,        32'h80000008, 1'b1);
      comb("br_maxpos", 1'b1, BR,   32'h8,        32'h7FFFFFFF, 32'h0,        32'h0,        1'b0);
      comb("sel_bad",   1'b1, BAD,  32'h12345678, 32'd4,        32'd4,        32'h0,        1'b0);
      comb("en0_jalr",  1'b0, JALR, 32'h2000,     32'h0,        32'd32,       32'h0,        1'b0);

      // held in reset across an edge: registers must not load
      drive(1'b1, JAL, 32'h1000, 32'd12, 32'h0);
      @(posedge clk); #1;
      chk("rst_hold_tq", target_q, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reg_tq", target_q, 32'h100C);
      chk("reg_kq", {31'd0, target_taken_q}, 32'h1);

      @(negedge clk);
      drive(1'b1, BR, 32'h3000, 32'd64, 32'h0);
      @(posedge clk); #1;
      chk("reg_nt_tq", target_q, 32'h0);
      chk("reg_nt_kq", {31'd0, target_taken_q}, 32'h0);

      @(negedge clk);
      drive(1'b1, JALR, 32'h2000, 32'h0, 32'd32);
      @(posedge clk); #1;
      chk("reg_jalr_tq", target_q, 32'h2020);

      // asynchronous clear between edges
      @(negedge clk);
      drive(1'b0, JAL, 32'h0, 32'h0, 32'h0);
      #1;
      chk("pre_arst_tq", target_q, 32'h2020);
      rst_n = 1'b0;
      #1;
      chk("arst_tq", target_q, 32'h0);
      chk("arst_kq", {31'd0, target_taken_q}, 32'h0);

`ifdef TGT_GEN_STATS_EN
      chk("cnt_rst_j", pred_jump_cnt, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, JAL, 32'h1000, 32'd12, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, JAL, 32'h1000, 32'hFFFFFFF0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, BR, 32'h3000, 32'hFFFFFFFC, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, BR, 32'h3000, 32'd64, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, BR, 32'h3000, 32'hFFFFFFFC, 32'h0);
      @(posedge clk); #1;
      chk("resume_nt_kq", {31'd0, target_taken_q}, 32'h0);
`ifdef TGT_GEN_STATS_EN
      chk("cnt_jump",  pred_jump_cnt,     32'd2);
      chk("cnt_br_t",  pred_br_taken_cnt, 32'd1);
      chk("cnt_br_nt", pred_br_nt_cnt,    32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/target_gen_pred.md
Name: target_gen_pred

Overview:
- Fetch-stage static target generator and branch predictor.
- From the decoded control-flow class, computes a redirect target and a taken flag:
  - JAL: always taken.
  - JALR: always taken.
  - Conditional branch: backward-taken / forward-not-taken (BTFN).
- Combinational outputs feed the same-cycle PC mux. Registered copies feed the next pipeline stage.

Parameters:
- XLEN, 32, datapath width of pc, rd1, imm and target.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  XLEN  PC of the instruction being predicted.
- sel  input  2  target class, encodings from control_sel.vh: `TGT_GEN_JAL=2'b00, `TGT_GEN_JALR=2'b01, `TGT_GEN_BR=2'b10; 2'b11 is invalid.
- en  input  1  instruction is a control-flow op; gates all outputs.
- rd1  input  XLEN  register operand used as the offset for JALR.
- imm  input  XLEN  sign-extended immediate, two's complement.
- target  output  XLEN  combinational predicted target.
- target_taken  output  1  combinational predict-taken flag.
- target_q  output  XLEN  target registered on clk.
- target_taken_q  output  1  target_taken registered on clk.

Behaviour:
- Combinational path, zero latency:
  - Default is target=0 and target_taken=0.
  - en=0: both outputs forced to 0, regardless of sel, pc, imm or rd1.
  - en=1, sel=JAL: target=pc+imm, taken=1.
  - en=1, sel=JALR: target=pc+rd1, taken=1. imm is ignored, and there is no LSB clearing.
  - en=1, sel=BR, imm[XLEN-1]=1 (negative): target=pc+imm, taken=1.
  - en=1, sel=BR, imm>=0 (including zero): target=0, taken=0.
  - en=1, sel=2'b11: target=0, taken=0.
- Arithmetic rules:
  - All sums are modulo 2^XLEN; wrap-around is silently truncated, with no carry or overflow output.
  - Sign is judged only from imm[XLEN-1]. The most negative imm, 0x8000_0000, counts as negative.
- Registered path:
  - On each rising clk edge: target_q<=target and target_taken_q<=target_taken.
  - Latency is exactly 1 cycle. There is no stall or enable; the registers are always loaded.
- Reset:
  - rst_n low asynchronously clears target_q and target_taken_q to 0 immediately, including mid-operation.
  - Registers resume loading on the first rising edge after rst_n rises.
  - The combinational outputs are unaffected by reset.
- No X propagation on unused inputs: rd1 is don't-care unless sel=JALR, and imm is don't-care when sel=JALR.

Optional Feature:
- Macro: TGT_GEN_STATS_EN.
- Defined: adds three 32-bit outputs.
  - pred_jump_cnt: increments on each clk where en=1 and sel is JAL or JALR.
  - pred_br_taken_cnt: increments where en=1, sel=BR and taken=1.
  - pred_br_nt_cnt: increments where en=1, sel=BR and taken=0.
  - All three wrap at 2^32 and are cleared asynchronously by rst_n low.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- en=0, sel=JAL, pc=0x1000, imm=12 -> target=0, taken=0; en=0, sel=BR, imm=-4 -> zeros.
- en=1 JAL:
  - pc=0x1000, imm=12 -> 0x100C, taken=1.
  - imm=0xFFFFFFF0 -> 0x0FF0.
  - pc=0xFFFFFFFC, imm=8 -> 0x00000004 (wrap).
- en=1 JALR:
  - pc=0x2000, rd1=32 -> 0x2020, taken=1.
  - rd1=0xFFFFFFE0 -> 0x1FE0.
  - pc=0xFFFFFFF0, rd1=64 -> 0x30.
- en=1 BR, pc=0x3000:
  - imm=-4 -> 0x2FFC, taken=1.
  - imm=64 -> 0, taken=0.
  - imm=0 -> 0, taken=0.
  - pc=8, imm=0x80000000 -> 0x80000008, taken=1.
- en=1, sel=2'b11, pc=0x12345678, imm=4, rd1=4 -> target=0, taken=0.
- Registered path:
  - JAL pc=0x1000, imm=12 applied -> target_q=0x100C, target_taken_q=1 after one rising edge.
  - Assert rst_n=0 between edges -> target_q=0 and target_taken_q=0 immediately, with no clock.
  - With TGT_GEN_STATS_EN: after 2 JAL, 1 taken BR and 1 not-taken BR cycles -> counters read 2, 1, 1.
